// File: rtl/flash_sample_streamer.sv
// flash_sample_streamer
// Prefetching flash reader for the audio playback path. Fetches 32-bit words
// from an Avalon-MM flash slave (one outstanding read, burstcount 1), buffers
// them in a small word FIFO and emits a 16-bit sample stream on a
// valid/ready interface, low half first, then high half.
//
// Optional feature macro: SAMPLE_ATTEN_EN
//   defined   : sample_data = signed half-word / 64, truncated toward zero
//   undefined : sample_data = raw half-word
module flash_sample_streamer #(
    parameter int NUM_WORDS  = 1048576,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          enable,
    input  logic                          restart,
    output logic                          flash_mem_read,
    output logic [22:0]                   flash_mem_address,
    input  logic                          flash_mem_waitrequest,
    input  logic [31:0]                   flash_mem_readdata,
    input  logic                          flash_mem_readdatavalid,
    output logic                          sample_valid,
    input  logic                          sample_ready,
    output logic [15:0]                   sample_data,
    output logic                          sample_last,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam logic [22:0] LAST_ADDR = 23'(NUM_WORDS - 1);
    localparam logic [LW:0] DEPTH_W   = (LW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    // Read engine state
    state_t       state_q, state_d;
    logic         read_q, read_d;
    logic [22:0]  addr_q, addr_d;
    logic         tag_q, tag_d;          // last-word tag of the outstanding read

    // Word FIFO: bit 32 is the last-word tag, bits 31:0 the flash word
    logic [32:0]   mem_q [FIFO_DEPTH];
    logic [32:0]   mem_d [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          half_q, half_d;

    logic          push_s;
    logic          pop_s;
    logic          hs_s;
    logic          valid_s;
    logic          pending_s;
    logic          room_s;
    logic [LW:0]   occ_s;
    logic [22:0]   next_addr_s;
    logic [32:0]   head_s;
    logic [15:0]   half_word_s;
    logic [15:0]   sample_s;

    // Read FSM: decide next state, command strobe, address and push
    always_comb begin
        state_d     = state_q;
        read_d      = 1'b0;
        addr_d      = addr_q;
        tag_d       = tag_q;
        push_s      = 1'b0;
        pending_s   = (state_q == ST_ISSUE) || (state_q == ST_WAIT);
        occ_s       = {1'b0, level_q} + {{LW{1'b0}}, pending_s};
        room_s      = (occ_s < DEPTH_W);
        next_addr_s = (addr_q == LAST_ADDR) ? 23'd0 : (addr_q + 23'd1);
        case (state_q)
            ST_IDLE: begin
                if (restart) begin
                    addr_d = 23'd0;
                end else if (enable && room_s) begin
                    state_d = ST_ISSUE;
                    read_d  = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (!flash_mem_waitrequest) begin
                    // Command accepted this cycle; data will follow
                    tag_d   = (addr_q == LAST_ADDR);
                    addr_d  = restart ? 23'd0 : next_addr_s;
                    state_d = restart ? ST_DRAIN : ST_WAIT;
                end else if (restart) begin
                    // Not yet accepted: simply drop the request
                    addr_d  = 23'd0;
                    state_d = ST_IDLE;
                end else begin
                    read_d  = 1'b1;
                end
            end
            ST_WAIT: begin
                if (restart) begin
                    addr_d  = 23'd0;
                    // A beat landing with restart is discarded right here
                    state_d = flash_mem_readdatavalid ? ST_IDLE : ST_DRAIN;
                end else if (flash_mem_readdatavalid) begin
                    push_s  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_DRAIN: begin
                addr_d = restart ? 23'd0 : addr_q;
                if (flash_mem_readdatavalid) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            default: begin
                state_d = ST_IDLE;
                read_d  = 1'b0;
            end
        endcase
    end

    // FIFO and unpacker: pointers, level, half select; restart wins over push/pop
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        half_d   = half_q;
        valid_s  = (level_q != {LW{1'b0}});
        hs_s     = valid_s && sample_ready;
        pop_s    = hs_s && half_q;
        if (restart) begin
            wr_ptr_d = {AW{1'b0}};
            rd_ptr_d = {AW{1'b0}};
            level_d  = {LW{1'b0}};
            half_d   = 1'b0;
        end else begin
            if (push_s) begin
                mem_d[wr_ptr_q] = {tag_q, flash_mem_readdata};
                wr_ptr_d        = wr_ptr_q + {{(AW-1){1'b0}}, 1'b1};
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (hs_s) begin
                half_d = !half_q;
            end else begin
                half_d = half_q;
            end
            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + {{(AW-1){1'b0}}, 1'b1};
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push_s, pop_s})
                2'b10:   level_d = level_q + {{(LW-1){1'b0}}, 1'b1};
                2'b01:   level_d = level_q - {{(LW-1){1'b0}}, 1'b1};
                default: level_d = level_q;
            endcase
        end
    end

    // Sample path: select the half-word at the FIFO head and optionally attenuate
    always_comb begin
        head_s      = mem_q[rd_ptr_q];
        half_word_s = half_q ? head_s[31:16] : head_s[15:0];
`ifdef SAMPLE_ATTEN_EN
        // Bias negatives by 63 so the arithmetic shift truncates toward zero
        sample_s = 16'($signed(half_word_s) +
                       (half_word_s[15] ? 16'sd63 : 16'sd0)) ;
        sample_s = 16'($signed(sample_s) >>> 4'd6);
`else
        sample_s = half_word_s;
`endif
    end

    // State and datapath registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            read_q   <= 1'b0;
            addr_q   <= 23'd0;
            tag_q    <= 1'b0;
            mem_q    <= '{default: 33'd0};
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            level_q  <= {LW{1'b0}};
            half_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            read_q   <= read_d;
            addr_q   <= addr_d;
            tag_q    <= tag_d;
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            half_q   <= half_d;
        end
    end

    assign flash_mem_read    = read_q;
    assign flash_mem_address = addr_q;
    assign fifo_level        = level_q;
    assign sample_valid      = valid_s;
    assign sample_data       = valid_s ? sample_s : 16'd0;
    assign sample_last       = valid_s && head_s[32] && half_q;

endmodule

// File: tb/tb_flash_sample_streamer.sv
// Directed testbench for flash_sample_streamer (NUM_WORDS=3, FIFO_DEPTH=4).
// A small flash model stalls each command for 2 cycles and returns data
// 3 cycles after acceptance. Expected samples follow the SAMPLE_ATTEN_EN build.
module tb_flash_sample_streamer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        restart;
    logic        flash_mem_read;
    logic [22:0] flash_mem_address;
    logic        flash_mem_waitrequest = 1'b1;
    logic [31:0] flash_mem_readdata = 32'd0;
    logic        flash_mem_readdatavalid = 1'b0;
    logic        sample_valid;
    logic        sample_ready;
    logic [15:0] sample_data;
    logic        sample_last;
    logic [2:0]  fifo_level;

    int checks   = 0;
    int failures = 0;

    // flash model state
    int          wcnt = 0;
    int          dcnt = 0;
    logic [22:0] acc_addr = 23'd0;
    logic [22:0] cmd_q[$];
    logic        ovr_en;
    logic [31:0] ovr_data;

    // sample monitor
    logic [15:0] sq[$];
    logic        lq[$];

    flash_sample_streamer #(.NUM_WORDS(3), .FIFO_DEPTH(4)) dut (
        .clk                     (clk),
        .rst_n                   (rst_n),
        .enable                  (enable),
        .restart                 (restart),
        .flash_mem_read          (flash_mem_read),
        .flash_mem_address       (flash_mem_address),
        .flash_mem_waitrequest   (flash_mem_waitrequest),
        .flash_mem_readdata      (flash_mem_readdata),
        .flash_mem_readdatavalid (flash_mem_readdatavalid),
        .sample_valid            (sample_valid),
        .sample_ready            (sample_ready),
        .sample_data             (sample_data),
        .sample_last             (sample_last),
        .fifo_level              (fifo_level)
    );

    // 100 MHz clock
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] flash_word(input logic [22:0] a);
        case (a)
            23'd0:   return 32'h2222_1111;
            23'd1:   return 32'h4444_3333;
            23'd2:   return 32'h6666_5555;
            default: return 32'h0000_0000;
        endcase
    endfunction

    function automatic logic [15:0] exp_s(input logic [15:0] h);
`ifdef SAMPLE_ATTEN_EN
        logic signed [15:0] s;
        s = h;
        return 16'(s / 16'sd64);
`else
        return h;
`endif
    endfunction

    function automatic logic [15:0] samp(input int i);
        return (i < sq.size()) ? sq[i] : 16'hxxxx;
    endfunction

    function automatic logic lastat(input int i);
        return (i < lq.size()) ? lq[i] : 1'bx;
    endfunction

    function automatic logic [22:0] cmdat(input int i);
        return (i < cmd_q.size()) ? cmd_q[i] : 23'hxxxxxx;
    endfunction

    // Flash slave model driven on the falling edge
    always @(negedge clk) begin
        flash_mem_readdatavalid = 1'b0;
        if (!rst_n) begin
            wcnt = 0;
            dcnt = 0;
            flash_mem_waitrequest = 1'b1;
        end else begin
            if (dcnt > 0) begin
                dcnt--;
                if (dcnt == 0) begin
                    flash_mem_readdatavalid = 1'b1;
                    flash_mem_readdata = ovr_en ? ovr_data : flash_word(acc_addr);
                end
            end
            if (flash_mem_read) begin
                if (wcnt < 2) begin
                    wcnt++;
                    flash_mem_waitrequest = 1'b1;
                end else begin
                    wcnt = 0;
                    flash_mem_waitrequest = 1'b0;
                    acc_addr = flash_mem_address;
                    cmd_q.push_back(acc_addr);
                    dcnt = 3;
                end
            end else begin
                wcnt = 0;
                flash_mem_waitrequest = 1'b1;
            end
        end
    end

    // Record every sample handshake
    always @(negedge clk) begin
        if (rst_n && sample_valid && sample_ready) begin
            sq.push_back(sample_data);
            lq.push_back(sample_last);
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_enable();
        enable = 1'b1;
        tick(1);
        enable = 1'b0;
    endtask

    task automatic pulse_restart();
        restart = 1'b1;
        tick(1);
        restart = 1'b0;
    endtask

    task automatic wait_samples(input int n, input int budget, input string tag);
        int k;
        k = 0;
        while (sq.size() < n && k < budget) begin
            tick(1);
            k++;
        end
        check_eq({tag, "_count"}, sq.size(), n);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_read"},  flash_mem_read,    1'b0);
        check_eq({tag, "_addr"},  flash_mem_address, 23'd0);
        check_eq({tag, "_valid"}, sample_valid,      1'b0);
        check_eq({tag, "_data"},  sample_data,       16'd0);
        check_eq({tag, "_last"},  sample_last,       1'b0);
        check_eq({tag, "_level"}, fifo_level,        3'd0);
    endtask

    initial begin
        logic [15:0] exp_stream [8];
        logic        seen;
        int          k;

        rst_n = 1'b0; enable = 1'b0; restart = 1'b0; sample_ready = 1'b0;
        ovr_en = 1'b0; ovr_data = 32'd0;
        tick(3);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        tick(2);

        // Basic fetch of word 0
        sample_ready = 1'b1;
        pulse_enable();
        wait_samples(2, 40, "basic");
        tick(3);
        check_eq("basic_s0", samp(0), exp_s(16'h1111));
        check_eq("basic_s1", samp(1), exp_s(16'h2222));
        check_eq("basic_cmds", cmd_q.size(), 1);
        check_eq("basic_cmd_addr", cmdat(0), 23'd0);
        check_eq("basic_addr", flash_mem_address, 23'd1);
        check_eq("basic_level", fifo_level, 3'd0);

        // Backpressure, fill, then wrap-around stream
        sample_ready = 1'b0;
        pulse_restart();
        sq.delete(); lq.delete(); cmd_q.delete();
        enable = 1'b1;
        tick(25);
        check_eq("bp_valid_mid", sample_valid, 1'b1);
        check_eq("bp_data_mid", sample_data, exp_s(16'h1111));
        tick(25);
        check_eq("bp_level", fifo_level, 3'd4);
        check_eq("bp_cmds", cmd_q.size(), 4);
        check_eq("bp_read_idle", flash_mem_read, 1'b0);
        check_eq("bp_data_end", sample_data, exp_s(16'h1111));
        check_eq("bp_last_stall", sample_last, 1'b0);
        sample_ready = 1'b1;
        wait_samples(8, 100, "bp");
        enable = 1'b0;
        exp_stream = '{16'h1111, 16'h2222, 16'h3333, 16'h4444,
                       16'h5555, 16'h6666, 16'h1111, 16'h2222};
        for (int i = 0; i < 8; i++) begin
            check_eq($sformatf("bp_s%0d", i), samp(i), exp_s(exp_stream[i]));
            check_eq($sformatf("wrap_last%0d", i), lastat(i), (i == 5) ? 1'b1 : 1'b0);
        end
        check_eq("wrap_cmd0", cmdat(0), 23'd0);
        check_eq("wrap_cmd1", cmdat(1), 23'd1);
        check_eq("wrap_cmd2", cmdat(2), 23'd2);
        check_eq("wrap_cmd3", cmdat(3), 23'd0);
        tick(40);
        check_eq("drain_level", fifo_level, 3'd0);
        check_eq("drain_valid", sample_valid, 1'b0);

        // Restart while a read is in flight
        sq.delete(); lq.delete(); cmd_q.delete();
        ovr_en = 1'b1; ovr_data = 32'hDEAD_BEEF;
        pulse_enable();
        seen = 1'b0;
        k = 0;
        while (k < 30) begin
            @(negedge clk);
            if (flash_mem_read) begin
                seen = 1'b1;
            end else if (seen) begin
                break;
            end
            k++;
        end
        check_eq("rs_accepted", seen, 1'b1);
        restart = 1'b1;
        @(posedge clk);
        #1;
        restart = 1'b0;
        check_eq("rs_level", fifo_level, 3'd0);
        check_eq("rs_addr", flash_mem_address, 23'd0);
        tick(10);
        check_eq("rs_no_output", sq.size(), 0);
        check_eq("rs_level_after", fifo_level, 3'd0);
        ovr_en = 1'b0;
        cmd_q.delete();
        pulse_enable();
        wait_samples(2, 40, "rs");
        check_eq("rs_cmd_addr", cmdat(0), 23'd0);
        check_eq("rs_s0", samp(0), exp_s(16'h1111));
        check_eq("rs_s1", samp(1), exp_s(16'h2222));

        // Attenuation word (raw build passes it through unchanged)
        tick(3);
        sq.delete(); lq.delete();
        ovr_en = 1'b1; ovr_data = 32'h8000_FFBF;
        pulse_enable();
        wait_samples(2, 40, "att");
`ifdef SAMPLE_ATTEN_EN
        check_eq("att_s0", samp(0), 16'hFFFF);
        check_eq("att_s1", samp(1), 16'hFE00);
`else
        check_eq("att_s0", samp(0), 16'hFFBF);
        check_eq("att_s1", samp(1), 16'h8000);
`endif
        check_eq("att_last1", lastat(1), 1'b0);
        ovr_en = 1'b0;
        tick(3);

        // Asynchronous reset while a command is pending and the FIFO holds data
        sample_ready = 1'b0;
        enable = 1'b1;
        seen = 1'b0;
        k = 0;
        while (k < 60 && !seen) begin
            @(negedge clk);
            seen = flash_mem_read && (fifo_level != 3'd0);
            k++;
        end
        check_eq("ar_busy", seen, 1'b1);
        #1;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("ar");
        enable = 1'b0;
        tick(3);
        rst_n = 1'b1;
        cmd_q.delete();
        tick(1);
        pulse_enable();
        k = 0;
        while (cmd_q.size() == 0 && k < 20) begin
            tick(1);
            k++;
        end
        check_eq("ar_cmd_count", cmd_q.size(), 1);
        check_eq("ar_cmd_addr", cmdat(0), 23'd0);
        tick(10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/flash_sample_streamer.md
# flash_sample_streamer

Prefetching flash reader that feeds the audio playback path. It fetches 32-bit words from the flash Avalon-MM slave, buffers them in a small word FIFO, and presents a 16-bit mono sample stream on a valid/ready interface: low half first, then high half. The audio codec writer sits downstream and consumes this stream; it applies its own per-sample repeat and skip for speed modes.

## Interface
- NUM_WORDS, 1048576: words played before the address wraps to 0.
- FIFO_DEPTH, 4: FIFO depth in words. Must be a power of 2, minimum 2.
- clk  in  1  system clock (CLOCK_50).
- rst_n  in  1  reset, asynchronous, active-low.
- enable  in  1  permits issuing new flash reads.
- restart  in  1  synchronous flush and restart from word 0.
- flash_mem_read  out  1  Avalon read request.
- flash_mem_address  out  23  word address.
- flash_mem_waitrequest  in  1  slave stall.
- flash_mem_readdata  in  32  read data.
- flash_mem_readdatavalid  in  1  read data strobe.
- sample_valid  out  1  sample_data is valid.
- sample_ready  in  1  consumer accepts the sample.
- sample_data  out  16  signed sample.
- sample_last  out  1  high on the final sample of the last word (address NUM_WORDS-1).
- fifo_level  out  $clog2(FIFO_DEPTH)+1  words currently held in the FIFO.

## Operation
- Read FSM states:
  - IDLE: go to ISSUE when enable && !restart && (fifo_level + pending) < FIFO_DEPTH. `pending` is 1 while a read is outstanding.
  - ISSUE: flash_mem_read=1 with a stable address. When waitrequest=0, the command is accepted; go to WAIT_DATA and advance the address.
  - WAIT_DATA: when readdatavalid=1, push {last_tag, readdata} into the FIFO and return to IDLE.
  - DRAIN: entered on restart while in ISSUE-accepted or WAIT_DATA. Discard the next readdatavalid beat, then go to IDLE.
- At most one read is outstanding; burstcount is fixed at 1.
- Address advance: increments by 1 on each accepted command. NUM_WORDS-1 wraps to 0.
- last_tag is set for the word fetched from address NUM_WORDS-1.
- Unpacker: a half bit selects readdata[15:0] when half=0 and [31:16] when half=1.
  - On each handshake (sample_valid && sample_ready): if half=0, set half=1; otherwise pop the FIFO and set half=0.
- sample_valid = FIFO not empty.
- sample_last = head last_tag && half=1.
- restart does all of the following in one cycle:
  - empties the FIFO and clears half to 0;
  - sets the address to 0;
  - leaves ISSUE before acceptance (drops read) by going to IDLE;
  - goes from WAIT_DATA to DRAIN.
- restart has priority over a simultaneous push or pop.
- enable low: no new command is issued. An in-flight read completes and is pushed. The output keeps draining.
- Simultaneous push and pop in one cycle: fifo_level is unchanged. This is legal while full, because a push only happens when space was reserved at issue.
- Reset values:
  - flash_mem_read 0, address 0
  - sample_valid 0, sample_data 0, sample_last 0
  - fifo_level 0, half 0, FSM in IDLE
- Reset is legal mid-transaction. Any data arriving after reset is ignored, because the FSM is in IDLE.

## Timing
- Command: flash_mem_read is registered and asserted the cycle after IDLE decides to issue. It is held until the cycle in which waitrequest is sampled low, and deasserts the next cycle.
- Latency from a readdatavalid edge at cycle N: sample_valid=1 at N+1 if the FIFO was empty. sample_data is valid in that same cycle.
- Throughput: one sample per cycle while the FIFO is non-empty. This is far above the audio rate, so the FIFO is normally full.
- sample_data and sample_last are driven combinationally from the FIFO head and the half bit. They must be stable while sample_valid=1 and sample_ready=0.
- fifo_level updates on the clock edge after a push or pop.

## Configuration
- SAMPLE_ATTEN_EN defined: sample_data = signed half-word / 64, truncating toward zero. Examples:
  - 16'h7FFF → 511
  - -1 → 0
  - -64 → -1
  - -65 → -1
  - 16'h8000 → -512
- SAMPLE_ATTEN_EN undefined: sample_data is the raw half-word. The downstream stage then owns attenuation.

## Test plan
- Basic fetch: flash model with waitrequest for 2 cycles and a readdatavalid latency of 3. Word 0 = 32'h2222_1111, ready held high. Required stream: 16'h1111 then 16'h2222 (raw build); address advances to 1.
- Backpressure and fill: sample_ready=0 for 50 cycles. Required: fifo_level saturates at 4 and exactly 4 commands are issued. Release ready: 8 samples emerge in address order, and sample_data stays stable while stalled.
- Wrap: NUM_WORDS=3, ready=1. Required addresses 0,1,2,0. sample_last is high only on the high half of word 2.
- Restart mid-read: assert restart during WAIT_DATA, then readdatavalid with 32'hDEAD_BEEF. Required: that word is never output; the next command uses address 0 and FIFO level is 0 after restart.
- Attenuation (SAMPLE_ATTEN_EN): word 32'h8000_FFBF. Required output: -1 (from -65), then -512.
- Async reset mid-burst: deassert rst_n while flash_mem_read=1. Required: all outputs return to reset values immediately; after release the first command uses address 0.
